// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit and its forwarding muxes.
package hazard_pkg;

  localparam int unsigned REG_IDX_W = 5;

  typedef enum logic [1:0] {
    FWD_REG,
    FWD_EX,
    FWD_MEM,
    FWD_WB
  } fwd_sel_e;

  typedef enum logic {
    RUN,
    MEM_WAIT
  } hz_state_e;

endpackage

// File: rtl/hazard_unit_fwd_mux.sv
// Single-operand bypass selector: picks the youngest in-flight producer of src_index.
module fwd_mux
  import hazard_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [REG_IDX_W-1:0] src_index,
  input  logic [XLEN-1:0]      reg_value,
  input  logic [REG_IDX_W-1:0] ex_rd_index,
  input  logic                 ex_fwd_en,
  input  logic [XLEN-1:0]      ex_value,
  input  logic [REG_IDX_W-1:0] mem_rd_index,
  input  logic                 mem_fwd_en,
  input  logic [XLEN-1:0]      mem_value,
  input  logic [REG_IDX_W-1:0] wb_rd_index,
  input  logic                 wb_fwd_en,
  input  logic [XLEN-1:0]      wb_value,
  output logic [XLEN-1:0]      fwd_value
);

  fwd_sel_e sel;

  // x0 is hard-wired, so it never takes a bypass even if a stage claims to write it
  always_comb begin
    sel = FWD_REG;
    if (src_index != '0) begin
      if (ex_fwd_en && (ex_rd_index == src_index))
        sel = FWD_EX;
      else if (mem_fwd_en && (mem_rd_index == src_index))
        sel = FWD_MEM;
      else if (wb_fwd_en && (wb_rd_index == src_index))
        sel = FWD_WB;
    end
  end

  always_comb begin
    fwd_value = reg_value;
    case (sel)
      FWD_EX:  fwd_value = ex_value;
      FWD_MEM: fwd_value = mem_value;
      FWD_WB:  fwd_value = wb_value;
      default: fwd_value = reg_value;
    endcase
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: operand forwarding, load-use bubbles, memory-wait hold,
// branch flush sequencing and a saturating stall-cycle counter.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [NUM_SRC*REG_IDX_W-1:0] id_src_index_i,
  input  logic [NUM_SRC-1:0]           id_src_used_i,
  input  logic [NUM_SRC*XLEN-1:0]      id_src_value_i,
  input  logic [REG_IDX_W-1:0]         ex_rd_index_i,
  input  logic                         ex_we_i,
  input  logic                         ex_is_load_i,
  input  logic [XLEN-1:0]              ex_alu_res_i,
  input  logic [REG_IDX_W-1:0]         mem_rd_index_i,
  input  logic                         mem_we_i,
  input  logic                         mem_is_load_i,
  input  logic [XLEN-1:0]              mem_alu_res_i,
  input  logic [XLEN-1:0]              mem_rdata_i,
  input  logic                         mem_rdata_valid_i,
  input  logic [REG_IDX_W-1:0]         wb_rd_index_i,
  input  logic                         wb_we_i,
  input  logic [XLEN-1:0]              wb_value_i,
  input  logic                         branch_taken_i,
  output logic [NUM_SRC*XLEN-1:0]      fwd_value_o,
  output logic                         stall_o,
  output logic                         bubble_o,
  output logic                         hold_o,
  output logic                         flush_o,
  output logic [CNT_W-1:0]             stall_cnt_o
);

  localparam int unsigned FC_W = $clog2(FLUSH_CYC + 1);

  hz_state_e          state;
  logic [FC_W-1:0]    flush_cnt;
  logic               flush_pend;
  logic               wait_active;
  logic               flush_active;
  logic               load_use;
  logic [XLEN-1:0]    mem_value;
  logic [NUM_SRC*XLEN-1:0] fwd_raw;

  assign mem_value = mem_is_load_i ? mem_rdata_i : mem_alu_res_i;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_mux #(.XLEN(XLEN)) u_fwd_mux (
      .src_index    (id_src_index_i[s*REG_IDX_W +: REG_IDX_W]),
      .reg_value    (id_src_value_i[s*XLEN +: XLEN]),
      .ex_rd_index  (ex_rd_index_i),
      .ex_fwd_en    (ex_we_i && !ex_is_load_i),
      .ex_value     (ex_alu_res_i),
      .mem_rd_index (mem_rd_index_i),
      .mem_fwd_en   (mem_we_i),
      .mem_value    (mem_value),
      .wb_rd_index  (wb_rd_index_i),
      .wb_fwd_en    (wb_we_i),
      .wb_value     (wb_value_i),
      .fwd_value    (fwd_raw[s*XLEN +: XLEN])
    );
  end

  always_comb begin
    load_use = 1'b0;
    if (ex_is_load_i && ex_we_i && (ex_rd_index_i != '0)) begin
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
        if (id_src_used_i[s] && (id_src_index_i[s*REG_IDX_W +: REG_IDX_W] == ex_rd_index_i))
          load_use = 1'b1;
      end
    end
  end

  // Hold asserts from the first cycle an unreturned load sits in MEM, not only after
  // the FSM has registered MEM_WAIT; the state just remembers the load is outstanding.
  assign wait_active  = !mem_rdata_valid_i && ((state == MEM_WAIT) || mem_is_load_i);
  assign flush_active = (flush_cnt != '0) && !wait_active;

  assign hold_o      = !reset_i && wait_active;
  assign flush_o     = !reset_i && flush_active;
  assign stall_o     = !reset_i && (wait_active || (load_use && !flush_active));
  assign bubble_o    = !reset_i && !wait_active && load_use && !flush_active;
  assign fwd_value_o = reset_i ? '0 : fwd_raw;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= RUN;
      flush_cnt   <= '0;
      flush_pend  <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      state <= wait_active ? MEM_WAIT : RUN;
      // Flush sequencing is frozen while held; a branch seen then is deferred.
      if (wait_active) begin
        if (branch_taken_i)
          flush_pend <= 1'b1;
      end else if (branch_taken_i || flush_pend) begin
        flush_cnt  <= FC_W'(FLUSH_CYC);
        flush_pend <= 1'b0;
      end else if (flush_cnt != '0) begin
        flush_cnt <= flush_cnt - FC_W'(1);
      end
      if ((stall_o || hold_o) && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboarded bench for hazard_unit: directed scenarios plus randomized traffic.
module tb_hazard_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NS    = 2;
  localparam int unsigned FC    = 2;
  localparam int unsigned CNT_W = 10;

  typedef struct {
    logic            rst;
    logic [NS*5-1:0] sidx;
    logic [NS-1:0]   used;
    logic [NS*XLEN-1:0] sval;
    logic [4:0]      ex_rd;
    logic            ex_we, ex_ld;
    logic [XLEN-1:0] ex_res;
    logic [4:0]      mem_rd;
    logic            mem_we, mem_ld, mem_vld;
    logic [XLEN-1:0] mem_res, mem_rdata;
    logic [4:0]      wb_rd;
    logic            wb_we;
    logic [XLEN-1:0] wb_val;
    logic            br;
  } stim_t;

  typedef struct {
    logic [NS*XLEN-1:0] fwd;
    logic stall, bubble, hold, flush;
    logic [CNT_W-1:0] cnt;
    string tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_i;
  logic [NS*5-1:0]      id_src_index_i;
  logic [NS-1:0]        id_src_used_i;
  logic [NS*XLEN-1:0]   id_src_value_i;
  logic [4:0]           ex_rd_index_i, mem_rd_index_i, wb_rd_index_i;
  logic                 ex_we_i, ex_is_load_i, mem_we_i, mem_is_load_i, mem_rdata_valid_i, wb_we_i;
  logic [XLEN-1:0]      ex_alu_res_i, mem_alu_res_i, mem_rdata_i, wb_value_i;
  logic                 branch_taken_i;
  logic [NS*XLEN-1:0]   fwd_value_o;
  logic                 stall_o, bubble_o, hold_o, flush_o;
  logic [CNT_W-1:0]     stall_cnt_o;

  hazard_unit #(.XLEN(XLEN), .NUM_SRC(NS), .FLUSH_CYC(FC), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .id_src_index_i(id_src_index_i), .id_src_used_i(id_src_used_i), .id_src_value_i(id_src_value_i),
    .ex_rd_index_i(ex_rd_index_i), .ex_we_i(ex_we_i), .ex_is_load_i(ex_is_load_i), .ex_alu_res_i(ex_alu_res_i),
    .mem_rd_index_i(mem_rd_index_i), .mem_we_i(mem_we_i), .mem_is_load_i(mem_is_load_i),
    .mem_alu_res_i(mem_alu_res_i), .mem_rdata_i(mem_rdata_i), .mem_rdata_valid_i(mem_rdata_valid_i),
    .wb_rd_index_i(wb_rd_index_i), .wb_we_i(wb_we_i), .wb_value_i(wb_value_i),
    .branch_taken_i(branch_taken_i),
    .fwd_value_o(fwd_value_o), .stall_o(stall_o), .bubble_o(bubble_o), .hold_o(hold_o),
    .flush_o(flush_o), .stall_cnt_o(stall_cnt_o)
  );

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: outstanding load, flush cycles remaining, deferred branch, stall count.
  bit m_wait = 0;
  int m_flush = 0;
  bit m_pend = 0;
  int m_cnt = 0;
  bit m_cnt_known = 0;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  task automatic check(input string name, input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: actual %0h required %0h at %0t", tag, name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.sval = {32'hCAFE_0001, 32'hBEEF_0000};
    return s;
  endfunction

  task automatic step(input stim_t s, input string tag);
    exp_t e;
    bit hold, flushing, lu;
    @(posedge clk);
    #1;
    reset_i = s.rst; id_src_index_i = s.sidx; id_src_used_i = s.used; id_src_value_i = s.sval;
    ex_rd_index_i = s.ex_rd; ex_we_i = s.ex_we; ex_is_load_i = s.ex_ld; ex_alu_res_i = s.ex_res;
    mem_rd_index_i = s.mem_rd; mem_we_i = s.mem_we; mem_is_load_i = s.mem_ld;
    mem_alu_res_i = s.mem_res; mem_rdata_i = s.mem_rdata; mem_rdata_valid_i = s.mem_vld;
    wb_rd_index_i = s.wb_rd; wb_we_i = s.wb_we; wb_value_i = s.wb_val; branch_taken_i = s.br;

    e.tag = tag;
    e.cnt = m_cnt[CNT_W-1:0];
    e.fwd = '0;
    hold = !s.mem_vld && (m_wait || s.mem_ld);
    flushing = (m_flush > 0) && !hold;
    lu = 0;
    for (int i = 0; i < NS; i++) begin
      logic [4:0] idx;
      logic [XLEN-1:0] v;
      idx = s.sidx[i*5 +: 5];
      v = s.sval[i*XLEN +: XLEN];
      if (idx != 0) begin
        if (s.ex_we && !s.ex_ld && s.ex_rd == idx) v = s.ex_res;
        else if (s.mem_we && s.mem_rd == idx) v = s.mem_ld ? s.mem_rdata : s.mem_res;
        else if (s.wb_we && s.wb_rd == idx) v = s.wb_val;
      end
      e.fwd[i*XLEN +: XLEN] = v;
      if (s.used[i] && idx == s.ex_rd) lu = 1;
    end
    lu = lu && s.ex_ld && s.ex_we && (s.ex_rd != 0);
    if (s.rst) begin
      e.fwd = '0; e.stall = 0; e.bubble = 0; e.hold = 0; e.flush = 0;
    end else begin
      e.hold   = hold;
      e.flush  = flushing;
      e.stall  = hold || (lu && !flushing);
      e.bubble = !hold && lu && !flushing;
    end
    if (m_cnt_known) q.push_back(e);

    if (s.rst) begin
      m_wait = 0; m_flush = 0; m_pend = 0; m_cnt = 0; m_cnt_known = 1;
    end else begin
      if ((e.stall || e.hold) && m_cnt < CNT_MAX) m_cnt++;
      m_wait = hold;
      if (hold) begin
        if (s.br) m_pend = 1;
      end else if (s.br || m_pend) begin
        m_flush = FC; m_pend = 0;
      end else if (m_flush > 0) begin
        m_flush--;
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("fwd",    e.tag, 64'(fwd_value_o), 64'(e.fwd));
        check("stall",  e.tag, 64'(stall_o),     64'(e.stall));
        check("bubble", e.tag, 64'(bubble_o),    64'(e.bubble));
        check("hold",   e.tag, 64'(hold_o),      64'(e.hold));
        check("flush",  e.tag, 64'(flush_o),     64'(e.flush));
        check("cnt",    e.tag, 64'(stall_cnt_o), 64'(e.cnt));
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    s = idle(); s.rst = 1;
    step(s, "reset"); step(s, "reset");

    s = idle(); s.ex_rd = 5; s.ex_we = 1; s.ex_res = 32'hA; s.mem_rd = 5; s.mem_we = 1; s.mem_res = 32'hB;
    s.sidx = {5'd0, 5'd5}; s.used = 2'b11;
    step(s, "ex_over_mem");
    s = idle(); s.ex_rd = 0; s.ex_we = 1; s.ex_res = 32'hDEAD; s.sidx = {5'd0, 5'd0}; s.used = 2'b11;
    step(s, "x0_no_fwd");
    s = idle(); s.mem_rd = 7; s.mem_we = 1; s.mem_ld = 1; s.mem_vld = 1; s.mem_rdata = 32'h1234;
    s.mem_res = 32'h9999; s.sidx = {5'd7, 5'd0}; s.used = 2'b10;
    step(s, "load_fwd_nohold");
    s = idle(); s.wb_rd = 9; s.wb_we = 1; s.wb_val = 32'h5151; s.sidx = {5'd9, 5'd9}; s.used = 2'b11;
    step(s, "wb_fwd");

    s = idle(); s.ex_rd = 3; s.ex_we = 1; s.ex_ld = 1; s.sidx = {5'd0, 5'd3}; s.used = 2'b01;
    step(s, "load_use");
    s.used = 2'b00;
    step(s, "load_unused");
    step(idle(), "idle");

    s = idle(); s.mem_rd = 4; s.mem_we = 1; s.mem_ld = 1; s.mem_vld = 0;
    repeat (3) step(s, "mem_wait");
    s.mem_vld = 1; s.mem_rdata = 32'h7777; s.sidx = {5'd4, 5'd0};
    step(s, "mem_return");
    step(idle(), "after_wait");

    s = idle(); s.mem_rd = 4; s.mem_we = 1; s.mem_ld = 1;
    step(s, "br_wait0");
    s.br = 1; step(s, "br_wait1");
    s.br = 0; step(s, "br_wait2");
    s.mem_vld = 1; step(s, "br_return");
    repeat (4) step(idle(), "pend_flush");

    s = idle(); s.br = 1; step(s, "branch");
    step(idle(), "flush1");
    step(s, "reload");
    s = idle(); s.ex_rd = 3; s.ex_we = 1; s.ex_ld = 1; s.sidx = {5'd0, 5'd3}; s.used = 2'b01;
    repeat (3) step(s, "flush_vs_lu");

    for (int i = 0; i < 400; i++) begin
      s = idle();
      s.rst = ($urandom_range(0, 99) == 0);
      s.sidx = 10'($urandom_range(0, 1023)) & 10'b00111_00111;
      s.used = 2'($urandom);
      s.sval = {$urandom, $urandom};
      s.ex_rd = 5'($urandom_range(0, 7)); s.ex_we = 1'($urandom); s.ex_ld = ($urandom_range(0, 3) == 0);
      s.ex_res = $urandom;
      s.mem_rd = 5'($urandom_range(0, 7)); s.mem_we = 1'($urandom);
      s.mem_ld = m_wait ? 1'b1 : ($urandom_range(0, 3) == 0);
      s.mem_vld = ($urandom_range(0, 2) == 0);
      s.mem_res = $urandom; s.mem_rdata = $urandom;
      s.wb_rd = 5'($urandom_range(0, 7)); s.wb_we = 1'($urandom); s.wb_val = $urandom;
      s.br = ($urandom_range(0, 9) == 0);
      step(s, "random");
    end

    s = idle(); s.rst = 1; step(s, "reset2");
    s = idle(); s.mem_rd = 2; s.mem_we = 1; s.mem_ld = 1;
    repeat (CNT_MAX + 8) step(s, "saturate");
    s.mem_vld = 1; step(s, "sat_return");
    step(idle(), "sat_hold");

    s = idle(); s.br = 1; step(s, "br_then_reset");
    step(idle(), "mid_flush");
    s = idle(); s.rst = 1; s.ex_rd = 3; s.ex_we = 1; s.ex_ld = 1; s.sidx = {5'd0, 5'd3}; s.used = 2'b01;
    s.mem_ld = 1;
    step(s, "reset_mid_flush");
    repeat (3) step(idle(), "post_reset");

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: actual %0d entries left required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
